// File: rtl/proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : proc_io_bridge
// Description : Buffered I/O bridge between external integer sample streams
//               and the soft-processor port interface. One FIFO per input
//               channel (valid/ready push, processor pop by address) and one
//               registered word plus one-cycle strobe per output channel.
//               Optional macro PROC_IO_LEVEL_EN adds per-channel occupancy
//               output in_level.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_io_bridge #(
    parameter int NB_IN  = 19,
    parameter int NB_OUT = 28,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int FDEPTH = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [NUIOIN*NB_IN-1:0]                           ext_in_data,
    input  logic [NUIOIN-1:0]                                 ext_in_valid,
    output logic [NUIOIN-1:0]                                 ext_in_ready,
    input  logic                                              proc_req_in,
    input  logic [((NUIOIN > 1) ? $clog2(NUIOIN) : 1)-1:0]    proc_addr_in,
    output logic [NB_IN-1:0]                                  proc_in_data,
    input  logic                                              proc_out_en,
    input  logic [((NUIOOU > 1) ? $clog2(NUIOOU) : 1)-1:0]    proc_addr_out,
    input  logic [NB_OUT-1:0]                                 proc_out_data,
    output logic [NUIOOU*NB_OUT-1:0]                          ext_out_data,
    output logic [NUIOOU-1:0]                                 ext_out_valid,
`ifdef PROC_IO_LEVEL_EN
    output logic [NUIOIN*($clog2(FDEPTH)+1)-1:0]              in_level,
`endif
    output logic [NUIOIN-1:0]                                 in_underflow
);

    localparam int c_ain_w  = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int c_aout_w = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int c_ptr_w  = $clog2(FDEPTH);
    localparam int c_lvl_w  = c_ptr_w + 1;

    // Channel counts widened by one bit so the range compare never truncates
    localparam logic [c_ain_w:0]  c_nin     = NUIOIN[c_ain_w:0];
    localparam logic [c_aout_w:0] c_nout    = NUIOOU[c_aout_w:0];
    localparam logic [c_ptr_w:0]  c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

    logic                w_addr_in_ok;
    logic                w_addr_out_ok;
    logic [NUIOIN-1:0]   w_empty;
    logic [NUIOIN-1:0]   w_full;
    logic [NB_IN-1:0]    w_rdata [NUIOIN];

    assign w_addr_in_ok  = ({1'b0, proc_addr_in} < c_nin);
    assign w_addr_out_ok = ({1'b0, proc_addr_out} < c_nout);

    // Ready is gated off while reset is held so no sample is taken during reset
    assign ext_in_ready = rst ? ~w_full : '0;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in_ch
        logic [NB_IN-1:0] r_mem [FDEPTH];
        logic [c_ptr_w:0] r_wptr;
        logic [c_ptr_w:0] r_rptr;
        logic [NB_IN-1:0] r_hold;
        logic             r_uflow;
        logic             w_sel;
        logic             w_push;
        logic             w_pop;

        assign w_sel      = proc_req_in && w_addr_in_ok && (proc_addr_in == c_ain_w'(k));
        assign w_empty[k] = (r_wptr == r_rptr);
        // Extra pointer MSB distinguishes full from empty when the low bits match
        assign w_full[k]  = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                            (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
        assign w_push     = ext_in_valid[k] && ext_in_ready[k];
        assign w_pop      = w_sel && !w_empty[k];
        // No bypass: an empty FIFO returns the last popped value
        assign w_rdata[k] = w_empty[k] ? r_hold : r_mem[r_rptr[c_ptr_w-1:0]];
        assign in_underflow[k] = r_uflow;

        // Sample storage; contents are don't-care until the pointers cover them
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wptr[c_ptr_w-1:0]] <= ext_in_data[k*NB_IN +: NB_IN];
            end
        end

        // Pointers, hold register and sticky underflow flag
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_hold  <= '0;
                r_uflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_ptr_one;
                    r_hold <= r_mem[r_rptr[c_ptr_w-1:0]];
                end
                if (w_sel && w_empty[k]) begin
                    r_uflow <= 1'b1;
                end
            end
        end

`ifdef PROC_IO_LEVEL_EN
        logic [c_lvl_w-1:0] r_level;

        // Occupancy counter tracking push/pop on the same edge
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_level <= '0;
            end else begin
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + c_ptr_one;
                    2'b01:   r_level <= r_level - c_ptr_one;
                    default: r_level <= r_level;
                endcase
            end
        end

        assign in_level[k*c_lvl_w +: c_lvl_w] = r_level;
`endif
    end

    // Processor read mux; out-of-range addresses read as zero
    always_comb begin
        proc_in_data = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (w_addr_in_ok && (proc_addr_in == c_ain_w'(k))) begin
                proc_in_data = w_rdata[k];
            end
        end
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out_ch
        logic              w_wr;
        logic [NB_OUT-1:0] r_data;
        logic              r_valid;

        assign w_wr = proc_out_en && w_addr_out_ok && (proc_addr_out == c_aout_w'(j));

        // Output word holds until rewritten; strobe lasts one cycle per write
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_wr;
                if (w_wr) begin
                    r_data <= proc_out_data;
                end
            end
        end

        assign ext_out_data[j*NB_OUT +: NB_OUT] = r_data;
        assign ext_out_valid[j]                 = r_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_io_bridge
// Description : Scoreboard bench for proc_io_bridge with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_io_bridge;

    localparam int NB_IN  = 19;
    localparam int NB_OUT = 28;
    localparam int NUIOIN = 4;
    localparam int NUIOOU = 4;
    localparam int FDEPTH = 4;

    typedef struct {
        logic [NUIOOU-1:0]        vld;
        logic [NUIOOU*NB_OUT-1:0] data;
    } out_item_t;

    logic                       clk;
    logic                       rst;
    logic [NUIOIN*NB_IN-1:0]    ext_in_data;
    logic [NUIOIN-1:0]          ext_in_valid;
    logic [NUIOIN-1:0]          ext_in_ready;
    logic                       proc_req_in;
    logic [1:0]                 proc_addr_in;
    logic [NB_IN-1:0]           proc_in_data;
    logic                       proc_out_en;
    logic [1:0]                 proc_addr_out;
    logic [NB_OUT-1:0]          proc_out_data;
    logic [NUIOOU*NB_OUT-1:0]   ext_out_data;
    logic [NUIOOU-1:0]          ext_out_valid;
    logic [NUIOIN-1:0]          in_underflow;
`ifdef PROC_IO_LEVEL_EN
    logic [NUIOIN*3-1:0]        in_level;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [NB_IN-1:0]         q_rd [$];
    out_item_t                q_out [$];
    logic [NUIOOU*NB_OUT-1:0] exp_out_data = '0;

    proc_io_bridge #(
        .NB_IN (NB_IN),
        .NB_OUT(NB_OUT),
        .NUIOIN(NUIOIN),
        .NUIOOU(NUIOOU),
        .FDEPTH(FDEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .proc_req_in  (proc_req_in),
        .proc_addr_in (proc_addr_in),
        .proc_in_data (proc_in_data),
        .proc_out_en  (proc_out_en),
        .proc_addr_out(proc_addr_out),
        .proc_out_data(proc_out_data),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
`ifdef PROC_IO_LEVEL_EN
        .in_level     (in_level),
`endif
        .in_underflow (in_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [NB_IN-1:0] v);
        ext_in_data[ch*NB_IN +: NB_IN] = v;
        ext_in_valid[ch] = 1'b1;
        idle();
        ext_in_valid[ch] = 1'b0;
    endtask

    task automatic pop(input int ch, input logic [NB_IN-1:0] exp);
        q_rd.push_back(exp);
        proc_addr_in = ch[1:0];
        proc_req_in  = 1'b1;
        idle();
        proc_req_in  = 1'b0;
    endtask

    task automatic push_pop(input int ch, input logic [NB_IN-1:0] v, input logic [NB_IN-1:0] exp);
        q_rd.push_back(exp);
        ext_in_data[ch*NB_IN +: NB_IN] = v;
        ext_in_valid[ch] = 1'b1;
        proc_addr_in = ch[1:0];
        proc_req_in  = 1'b1;
        idle();
        ext_in_valid[ch] = 1'b0;
        proc_req_in  = 1'b0;
    endtask

    task automatic write_out(input int ch, input logic [NB_OUT-1:0] v);
        out_item_t it;
        exp_out_data[ch*NB_OUT +: NB_OUT] = v;
        it.vld  = '0;
        it.vld[ch] = 1'b1;
        it.data = exp_out_data;
        q_out.push_back(it);
        proc_addr_out = ch[1:0];
        proc_out_data = v;
        proc_out_en   = 1'b1;
        idle();
        proc_out_en   = 1'b0;
    endtask

    // Monitor: compare every processor read and every output strobe against the scoreboard
    always @(negedge clk) begin
        logic [NB_IN-1:0] e;
        out_item_t        o;
        if (rst === 1'b1 && proc_req_in === 1'b1) begin
            if (q_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected none", proc_in_data);
            end else begin
                e = q_rd.pop_front();
                chk("proc_in_data", 128'(proc_in_data), 128'(e));
            end
        end
        if (ext_out_valid !== '0) begin
            if (q_out.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h expected none", ext_out_valid);
            end else begin
                o = q_out.pop_front();
                chk("ext_out_valid", 128'(ext_out_valid), 128'(o.vld));
                chk("ext_out_data", 128'(ext_out_data), 128'(o.data));
            end
        end
    end

    // Directed stimulus
    initial begin
        rst           = 1'b0;
        ext_in_valid  = '1;
        ext_in_data   = {NUIOIN{19'h01234}};
        proc_req_in   = 1'b0;
        proc_addr_in  = '0;
        proc_out_en   = 1'b0;
        proc_addr_out = '0;
        proc_out_data = '0;

        // Reset held with valid asserted: ready stays low, nothing enters
        repeat (2) begin
            idle();
            chk("ready_in_reset", 128'(ext_in_ready), 128'(4'h0));
        end
        rst          = 1'b1;
        ext_in_valid = '0;
        idle();
        chk("ready_after_reset", 128'(ext_in_ready), 128'(4'hF));
        chk("uflow_after_reset", 128'(in_underflow), 128'(4'h0));
        chk("oval_after_reset", 128'(ext_out_valid), 128'(4'h0));
        chk("odata_after_reset", 128'(ext_out_data), 128'(0));
        for (int a = 0; a < NUIOIN; a++) begin
            proc_addr_in = a[1:0];
            idle();
            chk("rdata_after_reset", 128'(proc_in_data), 128'(0));
        end

        // Fill ch2, then drain in order
        push(2, 19'd5);
        push(2, 19'h7FFFD);
        push(2, 19'd7);
        push(2, 19'd100);
        chk("ch2_full_ready", 128'(ext_in_ready), 128'(4'b1011));
        pop(2, 19'd5);
        pop(2, 19'h7FFFD);
        pop(2, 19'd7);
        pop(2, 19'd100);
        chk("ch2_ready_again", 128'(ext_in_ready), 128'(4'hF));

        // Underflow on ch1 returns the last popped value and is sticky
        push(1, 19'd9);
        pop(1, 19'd9);
        pop(1, 19'd9);
        chk("ch1_uflow", 128'(in_underflow), 128'(4'b0010));
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("ch1_uflow_sticky", 128'(in_underflow), 128'(4'b0010));
        end

        // Simultaneous push/pop on empty ch0: push only, hold (0) returned
        push_pop(0, 19'd42, 19'd0);
        chk("ch0_uflow", 128'(in_underflow), 128'(4'b0011));
        pop(0, 19'd42);

        // Full ch3: overflow push refused, push+pop while full pops only
        push(3, 19'd1);
        push(3, 19'd2);
        push(3, 19'd3);
        push(3, 19'd4);
        chk("ch3_full_ready", 128'(ext_in_ready[3]), 128'(1'b0));
        push(3, 19'd5);
        chk("ch3_still_full", 128'(ext_in_ready[3]), 128'(1'b0));
        push_pop(3, 19'd99, 19'd1);
        pop(3, 19'd2);
        pop(3, 19'd3);
        pop(3, 19'd4);
        pop(3, 19'd4);
        chk("ch3_uflow", 128'(in_underflow), 128'(4'b1011));

        // Pointer wrap on ch2
        push(2, 19'd11);
        push(2, 19'd12);
        pop(2, 19'd11);
        pop(2, 19'd12);

        // Back-to-back output writes
        write_out(3, 28'h7FFFFFF);
        write_out(0, 28'hFFFFFFF);
        idle();
        idle();
        chk("oval_idle", 128'(ext_out_valid), 128'(4'h0));
        chk("odata_hold", 128'(ext_out_data), 128'(exp_out_data));

        // Reset mid-operation discards queued samples and clears flags/outputs
        push(0, 19'd77);
        push(0, 19'd78);
        rst = 1'b0;
        idle();
        rst = 1'b1;
        exp_out_data = '0;
        proc_addr_in = 2'd0;
        #1;
        chk("midrst_rdata", 128'(proc_in_data), 128'(0));
        chk("midrst_uflow", 128'(in_underflow), 128'(4'h0));
        chk("midrst_ready", 128'(ext_in_ready), 128'(4'hF));
        chk("midrst_odata", 128'(ext_out_data), 128'(0));

`ifdef PROC_IO_LEVEL_EN
        idle();
        chk("lvl_reset", 128'(in_level), 128'(0));
        push(1, 19'd21);
        chk("lvl_1", 128'(in_level[3 +: 3]), 128'(3'd1));
        push(1, 19'd22);
        chk("lvl_2", 128'(in_level[3 +: 3]), 128'(3'd2));
        push(1, 19'd23);
        chk("lvl_3", 128'(in_level[3 +: 3]), 128'(3'd3));
        pop(1, 19'd21);
        chk("lvl_pop", 128'(in_level[3 +: 3]), 128'(3'd2));
        push(1, 19'd24);
        push(1, 19'd25);
        chk("lvl_full", 128'(in_level[3 +: 3]), 128'(3'd4));
        push(1, 19'd26);
        chk("lvl_full_hold", 128'(in_level[3 +: 3]), 128'(3'd4));
`endif

        idle();
        idle();
        chk("rd_queue_drained", 128'(q_rd.size()), 128'(0));
        chk("out_queue_drained", 128'(q_out.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog bounding the whole run
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/proc_io_bridge.md
Name: proc_io_bridge

Overview:
- Buffered, parametrised I/O bridge between external integer sample streams and the soft-processor port interface.
- Input side: one FIFO per input channel with valid/ready. The processor pops one word per req_in pulse, addressed by addr_in.
- Output side: the processor writes one word per out_en pulse into a per-channel register and emits a one-cycle valid strobe.
- Sits between the top-level pins and the int2float/float2int converters; it replaces the bare addr_dec pair.

Parameters:
- NB_IN, 19, input sample width (integer, two's complement)
- NB_OUT, 28, output sample width
- NUIOIN, 4, number of input channels (>=1)
- NUIOOU, 4, number of output channels (>=1)
- FDEPTH, 4, per-input-channel FIFO depth; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ext_in_data  in  NUIOIN*NB_IN  packed channel data; channel k occupies [k*NB_IN +: NB_IN]
- ext_in_valid  in  NUIOIN  per-channel write request
- ext_in_ready  out  NUIOIN  per-channel FIFO not full
- proc_req_in  in  1  processor read strobe
- proc_addr_in  in  max(1,$clog2(NUIOIN))  read channel select
- proc_in_data  out  NB_IN  data returned to processor
- proc_out_en  in  1  processor write strobe
- proc_addr_out  in  max(1,$clog2(NUIOOU))  write channel select
- proc_out_data  in  NB_OUT  data from processor
- ext_out_data  out  NUIOOU*NB_OUT  packed registered outputs
- ext_out_valid  out  NUIOOU  one-cycle write strobe per channel
- in_underflow  out  NUIOIN  sticky: read while channel was empty

Behaviour:
- Reset (rst==0 at posedge): all FIFOs empty, pointers 0; hold registers 0; ext_out_data 0; ext_out_valid 0; in_underflow 0.
- ext_in_ready is forced 0 while rst==0 (combinational gate). Otherwise ext_in_ready[k] = !full[k].
- Push: ext_in_valid[k] && ext_in_ready[k] at posedge writes the sample into FIFO k.
- Pop: proc_req_in==1 with proc_addr_in<NUIOIN at posedge.
  - FIFO not empty: pops the head into hold[addr].
  - FIFO empty: no pop; in_underflow[addr] is set.
- proc_in_data is combinational, valid in the same cycle as proc_req_in:
  - head of FIFO[addr] if that FIFO is not empty;
  - hold[addr] (last popped value) if it is empty;
  - 0 if proc_addr_in >= NUIOIN.
  - When proc_req_in==0, proc_in_data still reflects proc_addr_in.
- Simultaneous push and pop, same channel:
  - non-empty: both occur, count unchanged;
  - empty: push is accepted, pop is not; no bypass, so proc_in_data returns the hold value and underflow is set;
  - full: ready is already 0, so the push is refused and the pop proceeds.
- Pointers wrap modulo FDEPTH. Full/empty are derived from an extra pointer bit, giving exactly FDEPTH usable entries.
- Out-of-range proc_addr_in or proc_addr_out: the access is ignored, no flag changes.
- Output write: proc_out_en at posedge with proc_addr_out<NUIOOU:
  - ext_out_data slice[addr] <= proc_out_data;
  - ext_out_valid[addr] = 1 for exactly the next cycle, all other bits 0.
  - Data holds until the next write to that channel.
  - Back-to-back writes produce back-to-back strobes.
- in_underflow bits clear only on reset.
- Reset mid-operation: all queued samples are discarded; strobes and flags drop the cycle after the reset edge.

Optional Feature:
- Macro PROC_IO_LEVEL_EN.
  - Defined: adds output port in_level (NUIOIN*($clog2(FDEPTH)+1) bits, packed per channel), registered occupancy 0..FDEPTH, updated on the same edge as push/pop; reset 0.
  - Undefined: port absent, no occupancy counters synthesised.

Test Plan:
- Reset: hold rst=0 for 2 cycles with ext_in_valid=4'hF -> ext_in_ready=0, no pushes; after release, ready=4'hF, all outputs 0.
- Push ch2 values 5, -3, 7, 100 -> ready[2]=0 after the 4th push. Four req_in at addr 2 return 5, -3, 7, 100 in order; ready[2]=1 again.
- Read empty ch1 after popping 9 -> proc_in_data=9, in_underflow=4'b0010, sticky across 10 further cycles.
- Same-cycle push(42) and pop on empty ch0 -> proc_in_data=hold(0), underflow[0]=1. Next pop returns 42.
- out_en addr 3 data 28'h7FFFFFF, then addr 0 data -1 on consecutive cycles -> ext_out_valid 4'b1000 then 4'b0001. Both slices hold their values afterwards.
- With PROC_IO_LEVEL_EN: 3 pushes, 1 pop on ch1 -> in_level[ch1] sequence 1, 2, 3, 2. Push while full leaves it at 4.
